// File: rtl/rr_prio_stream_arbiter.sv
// N-to-1 valid/ready stream arbiter with fixed or round-robin priority,
// optional decision lock-in under sink backpressure, and payload mux.
module rr_prio_stream_arbiter #(
  parameter int NumReq     = 4,
  parameter int DataWidth  = 32,
  parameter bit RoundRobin = 1'b1,
  parameter bit LockIn     = 1'b1,
  localparam int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*DataWidth-1:0] data_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic                        req_o,
  input  logic                        gnt_i,
  output logic [DataWidth-1:0]        data_o,
  output logic [IdxWidth-1:0]         idx_o
);

  logic                r_lock;
  logic [IdxWidth-1:0] r_sel;
  logic [IdxWidth-1:0] r_rr;

  logic [IdxWidth-1:0] w_arb_idx;
  logic                w_hit;
  logic                w_lock_req;
  logic [IdxWidth-1:0] w_rr_nxt;
  logic                w_xfer;
  int                  w_base;

  // Two ascending passes: from the start pointer to the top, then wrap.
  always_comb begin
    w_base    = RoundRobin ? int'(r_rr) : 0;
    w_arb_idx = RoundRobin ? r_rr : '0;
    w_hit     = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!w_hit && req_i[i] && (i >= w_base)) begin
        w_hit     = 1'b1;
        w_arb_idx = IdxWidth'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!w_hit && req_i[i]) begin
        w_hit     = 1'b1;
        w_arb_idx = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    w_lock_req = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (r_sel == IdxWidth'(i)) w_lock_req = req_i[i];
    end
  end

  assign idx_o  = r_lock ? r_sel : w_arb_idx;
  assign req_o  = r_lock ? w_lock_req : |req_i;
  assign w_xfer = req_o & gnt_i;

  always_comb begin
    data_o = data_i[DataWidth-1:0];
    gnt_o  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (idx_o == IdxWidth'(i)) begin
        data_o   = data_i[i*DataWidth +: DataWidth];
        gnt_o[i] = gnt_i & req_o;
      end
    end
  end

  assign w_rr_nxt = (idx_o == IdxWidth'(NumReq - 1)) ? '0
                  : idx_o + IdxWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock <= 1'b0;
      r_sel  <= '0;
      r_rr   <= '0;
    end else if (flush_i) begin
      r_lock <= 1'b0;
      r_sel  <= '0;
      r_rr   <= '0;
    end else begin
      if (RoundRobin && w_xfer) r_rr <= w_rr_nxt;
      if (LockIn) begin
        if (w_xfer) begin
          r_lock <= 1'b0;
        end else if (r_lock && !w_lock_req) begin
          r_lock <= 1'b0;
        end else if (req_o && !gnt_i) begin
          r_lock <= 1'b1;
          r_sel  <= idx_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_prio_stream_arbiter.sv
// Scoreboard bench for rr_prio_stream_arbiter: round-robin, fixed,
// no-lock and single-requester instances share one stimulus bus.
module tb_rr_prio_stream_arbiter;

  typedef struct packed {
    logic        req;
    logic [1:0]  idx;
    logic [3:0]  gnt;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   req = '0;
  logic         gnt = 1'b0;
  logic [127:0] data;

  logic [3:0]  rr_gnt, fp_gnt, nl_gnt;
  logic        rr_req, fp_req, nl_req;
  logic [31:0] rr_data, fp_data, nl_data;
  logic [1:0]  rr_idx, fp_idx, nl_idx;
  logic        one_gnt, one_req, one_idx;
  logic [31:0] one_data;

  exp_t sb[$];
  exp_t e;
  exp_t a;
  int   n_chk = 0;
  int   n_fail = 0;

  assign data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  always #5 clk = ~clk;

  rr_prio_stream_arbiter #(.NumReq(4), .DataWidth(32),
    .RoundRobin(1'b1), .LockIn(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_i(req), .data_i(data), .gnt_o(rr_gnt),
    .req_o(rr_req), .gnt_i(gnt), .data_o(rr_data),
    .idx_o(rr_idx));

  rr_prio_stream_arbiter #(.NumReq(4), .DataWidth(32),
    .RoundRobin(1'b0), .LockIn(1'b1)) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_i(req), .data_i(data), .gnt_o(fp_gnt),
    .req_o(fp_req), .gnt_i(gnt), .data_o(fp_data),
    .idx_o(fp_idx));

  rr_prio_stream_arbiter #(.NumReq(4), .DataWidth(32),
    .RoundRobin(1'b0), .LockIn(1'b0)) u_nl (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_i(req), .data_i(data), .gnt_o(nl_gnt),
    .req_o(nl_req), .gnt_i(gnt), .data_o(nl_data),
    .idx_o(nl_idx));

  rr_prio_stream_arbiter #(.NumReq(1), .DataWidth(32),
    .RoundRobin(1'b1), .LockIn(1'b1)) u_one (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_i(req[0]), .data_i(data[31:0]), .gnt_o(one_gnt),
    .req_o(one_req), .gnt_i(gnt), .data_o(one_data),
    .idx_o(one_idx));

  function automatic exp_t mk(logic r, logic [1:0] i, logic [3:0] g);
    exp_t x;
    x.req  = r;
    x.idx  = i;
    x.gnt  = g;
    x.data = 32'hA0 + 32'(i);
    return x;
  endfunction

  task automatic cyc(logic [3:0] r, logic g, logic f);
    @(negedge clk);
    req   = r;
    gnt   = g;
    flush = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    gnt   = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0110;
    gnt   = 1'b0;
    sb.push_back(mk(1'b1, 2'd1, 4'b0000));
    sb.push_back(mk(1'b1, 2'd1, 4'b0000));
    @(posedge clk);
    #2;
    e = sb.pop_front();
    a = {rr_req, rr_idx, rr_gnt, rr_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL reset_rr: got %h want %h", a, e);
    end
    e = sb.pop_front();
    a = {fp_req, fp_idx, fp_gnt, fp_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL reset_fp: got %h want %h", a, e);
    end
    do_reset();
  endtask

  task automatic test_fixed();
    logic [3:0] rs [3] = '{4'b1010, 4'b1000, 4'b0000};
    exp_t es [3];
    es[0] = mk(1'b1, 2'd1, 4'b0010);
    es[1] = mk(1'b1, 2'd3, 4'b1000);
    es[2] = mk(1'b0, 2'd0, 4'b0000);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(rs[k], 1'b1, 1'b0);
      sb.push_back(es[k]);
      #1;
      e = sb.pop_front();
      a = {fp_req, fp_idx, fp_gnt, fp_data};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL fixed_%0d: got %h want %h", k, a, e);
      end
    end
  endtask

  task automatic test_rr_rotation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      sb.push_back(mk(1'b1, 2'(k % 4), 4'b0001 << (k % 4)));
    end
    for (int k = 0; k < 5; k++) ;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      #1;
      e = sb.pop_front();
      a = {rr_req, rr_idx, rr_gnt, rr_data};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rr_rot_%0d: got %h want %h", k, a, e);
      end
    end
    cyc(4'b0000, 1'b1, 1'b0);
    sb.push_back(mk(1'b0, 2'd1, 4'b0000));
    #1;
    e = sb.pop_front();
    a = {rr_req, rr_idx, rr_gnt, rr_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL rr_idle: got %h want %h", a, e);
    end
    cyc(4'b0100, 1'b1, 1'b0);
    sb.push_back(mk(1'b1, 2'd2, 4'b0100));
    #1;
    e = sb.pop_front();
    a = {rr_req, rr_idx, rr_gnt, rr_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL rr_skip: got %h want %h", a, e);
    end
    cyc(4'b0011, 1'b1, 1'b0);
    sb.push_back(mk(1'b1, 2'd0, 4'b0001));
    #1;
    e = sb.pop_front();
    a = {rr_req, rr_idx, rr_gnt, rr_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL rr_wrap: got %h want %h", a, e);
    end
  endtask

  task automatic test_lock();
    logic [3:0] rs [4] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101};
    logic       gs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_t fe [4];
    exp_t ne [4];
    fe[0] = mk(1'b1, 2'd2, 4'b0000);
    fe[1] = mk(1'b1, 2'd2, 4'b0000);
    fe[2] = mk(1'b1, 2'd2, 4'b0100);
    fe[3] = mk(1'b1, 2'd0, 4'b0001);
    ne[0] = mk(1'b1, 2'd2, 4'b0000);
    ne[1] = mk(1'b1, 2'd0, 4'b0000);
    ne[2] = mk(1'b1, 2'd0, 4'b0001);
    ne[3] = mk(1'b1, 2'd0, 4'b0001);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(rs[k], gs[k], 1'b0);
      sb.push_back(fe[k]);
      sb.push_back(ne[k]);
      #1;
      e = sb.pop_front();
      a = {fp_req, fp_idx, fp_gnt, fp_data};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL lock_fp_%0d: got %h want %h", k, a, e);
      end
      e = sb.pop_front();
      a = {nl_req, nl_idx, nl_gnt, nl_data};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL lock_off_%0d: got %h want %h", k, a, e);
      end
    end
  endtask

  task automatic test_flush();
    logic [3:0] rs [6] = '{4'b0010, 4'b1000, 4'b1001,
                          4'b1001, 4'b1111, 4'b1111};
    logic       gs [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       fs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t es [6];
    es[0] = mk(1'b1, 2'd1, 4'b0010);
    es[1] = mk(1'b1, 2'd3, 4'b0000);
    es[2] = mk(1'b1, 2'd3, 4'b0000);
    es[3] = mk(1'b1, 2'd0, 4'b0000);
    es[4] = mk(1'b1, 2'd0, 4'b0001);
    es[5] = mk(1'b1, 2'd0, 4'b0000);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(rs[k], gs[k], fs[k]);
      sb.push_back(es[k]);
      #1;
      e = sb.pop_front();
      a = {rr_req, rr_idx, rr_gnt, rr_data};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL flush_%0d: got %h want %h", k, a, e);
      end
    end
    cyc(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_drop();
    logic [3:0] rs [3] = '{4'b0100, 4'b0001, 4'b0001};
    exp_t es [3];
    es[0] = mk(1'b1, 2'd2, 4'b0000);
    es[1] = mk(1'b0, 2'd2, 4'b0000);
    es[2] = mk(1'b1, 2'd0, 4'b0000);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(rs[k], 1'b0, 1'b0);
      sb.push_back(es[k]);
      #1;
      e = sb.pop_front();
      a = {fp_req, fp_idx, fp_gnt, fp_data};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL drop_%0d: got %h want %h", k, a, e);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(4'b0001, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    sb.push_back(mk(1'b1, 2'd3, 4'b0000));
    #1;
    e = sb.pop_front();
    a = {rr_req, rr_idx, rr_gnt, rr_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL arst_setup: got %h want %h", a, e);
    end
    cyc(4'b0011, 1'b0, 1'b0);
    sb.push_back(mk(1'b0, 2'd3, 4'b0000));
    sb.push_back(mk(1'b1, 2'd0, 4'b0000));
    #1;
    e = sb.pop_front();
    a = {rr_req, rr_idx, rr_gnt, rr_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL arst_locked: got %h want %h", a, e);
    end
    rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    a = {rr_req, rr_idx, rr_gnt, rr_data};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL arst_drop: got %h want %h", a, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] rs [3] = '{4'b0001, 4'b0001, 4'b0000};
    exp_t es [3];
    es[0] = mk(1'b1, 2'd0, 4'b0001);
    es[1] = mk(1'b1, 2'd0, 4'b0001);
    es[2] = mk(1'b0, 2'd0, 4'b0000);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(rs[k], 1'b1, 1'b0);
      sb.push_back(es[k]);
      #1;
      e = sb.pop_front();
      a = {one_req, 1'b0, one_idx, 3'b000, one_gnt, one_data};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL single_%0d: got %h want %h", k, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_lock();
    test_flush();
    test_drop();
    test_async_reset();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
